// File: rtl/vector_mem_pkg.sv
// Shared types and constants for the vector memory responder: FSM states,
// latency counter width, byte-to-word address shift and the address check.
package vector_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W      = 4;
    localparam int WORD_SHIFT = 2;

    // Widened compare so DEPTH*4 cannot overflow and silently wrap.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) << WORD_SHIFT;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module word_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/vector_mem_responder.sv
// Single-outstanding word memory responder with fixed request-to-response
// latency; misaligned or out-of-range requests answer with rsp_err.
module vector_mem_responder
    import vector_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             wen_reg, err_reg;
    logic [AW-1:0]    idx_reg;
    logic [31:0]      wdata_reg;

    logic             accept, req_err, enter_resp;
    logic [AW-1:0]    req_idx, ram_idx;
    logic             sel_wen, sel_err, ram_we;
    logic [31:0]      sel_wdata, ram_rdata;

    assign req_err = addr_err(req_addr, DEPTH);
    assign req_idx = AW'(req_addr >> WORD_SHIFT);
    assign accept  = req_valid && (state_reg == IDLE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
        if (accept) begin
            wen_reg   <= req_wen;
            err_reg   <= req_err;
            idx_reg   <= req_idx;
            wdata_reg <= req_wdata;
        end
    end

    // With LATENCY=1 the write commits on the accept edge itself, so the
    // RAM port must see the live request rather than the latched copy.
    always_comb begin
        ram_idx   = idx_reg;
        sel_wen   = wen_reg;
        sel_err   = err_reg;
        sel_wdata = wdata_reg;
        if (state_reg == IDLE) begin
            ram_idx   = req_idx;
            sel_wen   = req_wen;
            sel_err   = req_err;
            sel_wdata = req_wdata;
        end
    end

    assign enter_resp = (state_reg != RESP) && (state_next == RESP);
    assign ram_we     = !rst && enter_resp && sel_wen && !sel_err;

    word_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_word_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_idx),
        .wdata(sel_wdata),
        .rdata(ram_rdata)
    );

    assign req_ready = (state_reg == IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_data  = (rsp_valid && !err_reg && !wen_reg) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed bench for vector_mem_responder: scoreboard of expected responses
// with expected response cycle, checked by a negedge monitor.
module tb_vector_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ncmp  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    int   last_acc = 0;

    vector_mem_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid strobe.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("busy_eq_not_ready", {31'b0, busy}, {31'b0, !req_ready});
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e.cyc);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    check("rsp_data", rsp_data, e.data);
                    check("busy_in_resp", {31'b0, busy}, 32'd1);
                    $display("rsp  cyc=%0d err=%0b data=0x%08h", cyc, rsp_err, rsp_data);
                end
            end else begin
                check("idle_rsp_zero", {31'b0, rsp_err} | rsp_data, 32'd0);
            end
        end
    end

    // Present a request at a negedge, hold it until accepted, then return at
    // the negedge following the accept edge with req_valid still high.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_data, input bit expect_rsp);
        int waited;
        exp_t e;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            last_acc = cyc;
            if (expect_rsp) begin
                e.err  = exp_err;
                e.data = exp_data;
                e.cyc  = cyc + LATENCY;
                exp_q.push_back(e);
            end
            $display("req  cyc=%0d wen=%0b addr=0x%08h wdata=0x%08h", cyc, wen, addr, wdata);
        end
        @(negedge clk);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int prev_acc;
        int waited;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        issue(1'b1, 32'h10, 32'h0000_00AA, 1'b0, 32'h0, 1'b1);
        go_idle();
        issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_00AA, 1'b1);
        go_idle();

        issue(1'b1, 32'h3FC, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h3FC, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 32'h400, 32'h1111_1111, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 32'h0, 32'h7777_0000, 1'b0, 32'h0, 1'b1);
        go_idle();

        issue(1'b1, 32'h12, 32'h0000_00FF, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_00AA, 1'b1);
        issue(1'b1, 32'h20, 32'h0000_5555, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h0, 32'h0, 1'b0, 32'h7777_0000, 1'b1);

        // Four back-to-back reads with req_valid never dropped.
        issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_00AA, 1'b1);
        prev_acc = last_acc;
        issue(1'b0, 32'h3FC, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        check("b2b_spacing_1", last_acc - prev_acc, LATENCY + 1);
        prev_acc = last_acc;
        issue(1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_5555, 1'b1);
        check("b2b_spacing_2", last_acc - prev_acc, LATENCY + 1);
        prev_acc = last_acc;
        issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_00AA, 1'b1);
        check("b2b_spacing_3", last_acc - prev_acc, LATENCY + 1);
        go_idle();
        go_idle();

        // Reset lands while the write sits in WAIT; it must be abandoned.
        issue(1'b1, 32'h20, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_5555, 1'b1);
        go_idle();

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
